// File: rtl/playseq_gravador.sv
// PlaySeq sequence recorder: captures one-hot button presses and writes them in
// order into the 16x4 user sequence RAM, reporting how many moves were stored.
module playseq_gravador #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [3:0] ram_data,
    output logic [4:0] tamanho,
    output logic       gravando,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        ESPERA  = 3'd1,
        GRAVA   = 3'd2,
        SOLTA   = 3'd3,
        FIM     = 3'd4,
        ERRO    = 3'd5
    } estado_t;

    estado_t       r_estado;
    estado_t       w_estado_nx;
    logic [3:0]    r_b_r;
    logic [3:0]    r_b_p;
    logic [3:0]    r_endereco;
    logic [3:0]    w_endereco_nx;
    logic [3:0]    r_dado;
    logic [3:0]    w_dado_nx;
    logic [4:0]    r_tamanho;
    logic [4:0]    w_tamanho_nx;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nx;
    logic          w_ev;
    logic          w_onehot;

    assign w_ev     = (|r_b_r) & ~(|r_b_p);
    assign w_onehot = (r_b_r != '0) && ((r_b_r & (r_b_r - 4'd1)) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= INICIAL;
            r_b_r      <= '0;
            r_b_p      <= '0;
            r_endereco <= '0;
            r_dado     <= '0;
            r_tamanho  <= '0;
            r_cnt      <= '0;
        end else begin
            r_estado   <= w_estado_nx;
            r_b_r      <= botoes;
            r_b_p      <= r_b_r;
            r_endereco <= w_endereco_nx;
            r_dado     <= w_dado_nx;
            r_tamanho  <= w_tamanho_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    always_comb begin
        w_estado_nx   = r_estado;
        w_endereco_nx = r_endereco;
        w_dado_nx     = r_dado;
        w_tamanho_nx  = r_tamanho;
        w_cnt_nx      = r_cnt;
        case (r_estado)
            INICIAL, FIM, ERRO: begin
                if (iniciar) begin
                    w_endereco_nx = '0;
                    w_tamanho_nx  = '0;
                    w_cnt_nx      = '0;
                    w_estado_nx   = ESPERA;
                end
            end
            ESPERA: begin
                // A press edge takes priority over an expiring timeout.
                if (w_ev) begin
                    if (w_onehot) begin
                        w_dado_nx   = r_b_r;
                        w_estado_nx = GRAVA;
                    end else begin
                        w_estado_nx = ERRO;
                    end
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    w_estado_nx = (r_tamanho != '0) ? FIM : ERRO;
                end else begin
                    w_cnt_nx = r_cnt + TW'(1);
                end
            end
            GRAVA: begin
                w_tamanho_nx  = r_tamanho + 5'd1;
                w_endereco_nx = r_endereco + 4'd1;
                w_estado_nx   = (r_endereco == 4'd15) ? FIM : SOLTA;
            end
            SOLTA: begin
                if (r_b_r == '0) begin
                    w_cnt_nx    = '0;
                    w_estado_nx = ESPERA;
                end
            end
            default: w_estado_nx = INICIAL;
        endcase
    end

    always_comb begin
        ram_we    = (r_estado == GRAVA);
        ram_addr  = r_endereco;
        ram_data  = r_dado;
        tamanho   = r_tamanho;
        gravando  = (r_estado == ESPERA) || (r_estado == GRAVA) || (r_estado == SOLTA);
        pronto    = (r_estado == FIM);
        erro      = (r_estado == ERRO);
        db_estado = r_estado;
    end

endmodule
